// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS controller FSM.
// Sequences a shared ALU, a unified instruction/data memory and the register file
// through fetch/decode/execute/memory/writeback. Memory accesses wait on mem_ready.
// A watchdog sends the FSM to HALT if an access stalls too long.
//
// Parameters:
//   TIMEOUT_CYCLES : max mem_ready-low cycles per access (0 disables the watchdog)
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   opcode, funct     : IR[31:26] / IR[5:0], opcode valid from DECODE onward
//   zero              : ALU zero flag (branch decision)
//   mem_ready         : memory completes the current access this cycle
//   pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   ext_op, alu_src_a, alu_src_b, alu_op, pc_source : datapath controls
//   instr_done        : pulse on the last cycle of each instruction
//   illegal           : pulse when an unsupported opcode/funct is decoded
//   halted            : high while in HALT
//   state             : current state (debug)
module multi_cycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       ext_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value on the last permitted wait cycle of an access.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StExecI   = 4'd10,
        StIWb     = 4'd11,
        StHalt    = 4'd15
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       r_funct_ok;
    logic       r_is_shift;
    logic [3:0] r_alu_op;
    logic       op_legal;
    logic       is_wait_state;
    logic       timeout;

    // R-type funct decode.
    always_comb begin
        r_funct_ok = 1'b1;
        r_is_shift = 1'b0;
        r_alu_op   = ALU_ADD;
        case (funct)
            6'b100000: r_alu_op = ALU_ADD;
            6'b100010: r_alu_op = ALU_SUB;
            6'b100100: r_alu_op = ALU_AND;
            6'b100101: r_alu_op = ALU_OR;
            6'b100110: r_alu_op = ALU_XOR;
            6'b000000: begin r_alu_op = ALU_SLL; r_is_shift = 1'b1; end
            6'b000010: begin r_alu_op = ALU_SRL; r_is_shift = 1'b1; end
            6'b000011: begin r_alu_op = ALU_SRA; r_is_shift = 1'b1; end
            6'b101010: r_alu_op = ALU_SLT;
            6'b101011: r_alu_op = ALU_SLTU;
            default:   r_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_RTYPE:                                     op_legal = r_funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI:  op_legal = 1'b1;
            default:                                      op_legal = 1'b0;
        endcase
    end

    assign is_wait_state = (state_q == StFetch) || (state_q == StMemRd) ||
                           (state_q == StMemWr);
    // mem_ready on the final wait cycle still completes the access.
    assign timeout = (TIMEOUT_CYCLES != 0) && is_wait_state && !mem_ready &&
                     (cnt_q == LAST_WAIT);

    // State register and watchdog counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (timeout)        state_d = StHalt;
                else if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW:    state_d = StMemAddr;
                    OP_RTYPE:        state_d = r_funct_ok ? StExecR : StFetch;
                    OP_BEQ:          state_d = StBranch;
                    OP_J:            state_d = StJump;
                    OP_ADDI, OP_ORI: state_d = StExecI;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAddr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd: begin
                if (timeout)        state_d = StHalt;
                else if (mem_ready) state_d = StMemWb;
            end
            StMemWr: begin
                if (timeout)        state_d = StHalt;
                else if (mem_ready) state_d = StFetch;
            end
            StExecR:  state_d = StRWb;
            StExecI:  state_d = StIWb;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // Only a wait state looping on itself keeps counting; any transition clears.
    always_comb begin
        if (is_wait_state && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
        else                                       cnt_d = '0;
    end

    // Output logic.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        ext_op     = 1'b1;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_source  = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                illegal   = !op_legal;
            end
            StMemAddr: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            StExecR: begin
                alu_src_a = r_is_shift ? 2'b10 : 2'b01;
                alu_op    = r_alu_op;
            end
            StRWb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                alu_op     = r_alu_op;
                instr_done = 1'b1;
            end
            StBranch: begin
                alu_src_a  = 2'b01;
                alu_op     = ALU_SUB;
                pc_source  = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            StJump: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            StExecI: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                ext_op    = (opcode != OP_ORI);
            end
            StIWb: begin
                reg_write  = 1'b1;
                alu_op     = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                ext_op     = (opcode != OP_ORI);
                instr_done = 1'b1;
            end
            StHalt: halted = 1'b1;
            default: ;
        endcase
        // Reset silences everything, including the FETCH read request.
        if (rst) begin
            pc_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            ext_op     = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = ALU_ADD;
            pc_source  = 2'b00;
            instr_done = 1'b0;
            illegal    = 1'b0;
            halted     = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control with a per-instruction behavioural model.
module tb_multi_cycle_control;

    localparam int unsigned TO = 16;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0d;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, ext_op, instr_done, illegal, halted;
    logic [1:0] alu_src_a, alu_src_b, pc_source;
    logic [3:0] alu_op, state;

    typedef struct packed {
        logic       pc_write, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, ext_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done, illegal, halted;
        logic [3:0] state;
    } outs_t;

    outs_t dut_o, exp_o;
    outs_t snap[16];
    int    seen[$];
    int    plan[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  chk_en = 1'b0;

    always #5 clk = ~clk;

    multi_cycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .ext_op(ext_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
        .halted(halted), .state(state)
    );

    assign dut_o = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, ext_op, alu_src_a, alu_src_b, alu_op, pc_source,
                    instr_done, illegal, halted, state};

    // {valid, alu code} for an R-type funct.
    function automatic logic [4:0] alu_of(logic [5:0] fn);
        case (fn)
            6'h20: return 5'h10;
            6'h22: return 5'h11;
            6'h24: return 5'h12;
            6'h25: return 5'h13;
            6'h26: return 5'h14;
            6'h00: return 5'h15;
            6'h02: return 5'h16;
            6'h03: return 5'h17;
            6'h2a: return 5'h18;
            6'h2b: return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    // Instruction class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ADDI/ORI, 6 illegal.
    function automatic int cls(logic [5:0] op, logic [5:0] fn);
        if (op == OP_R) return alu_of(fn)[4] ? 0 : 6;
        if (op == OP_LW) return 1;
        if (op == OP_SW) return 2;
        if (op == OP_BEQ) return 3;
        if (op == OP_J) return 4;
        if (op == OP_ADDI || op == OP_ORI) return 5;
        return 6;
    endfunction

    // Sequence of step numbers an instruction walks through.
    function automatic void make_plan(int c);
        plan = '{0, 1};
        case (c)
            0: begin plan.push_back(6); plan.push_back(7); end
            1: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
            2: begin plan.push_back(2); plan.push_back(5); end
            3: plan.push_back(8);
            4: plan.push_back(9);
            5: begin plan.push_back(10); plan.push_back(11); end
            default: ;
        endcase
    endfunction

    function automatic outs_t model(int ph, logic [5:0] op, logic [5:0] fn, logic z,
                                    logic mr, logic r);
        outs_t       o;
        logic [4:0]  a;
        logic        ori;
        o = '0;
        if (r) return o;
        a = alu_of(fn);
        ori = (op == OP_ORI);
        o.ext_op = 1'b1;
        o.state = 4'(ph);
        case (ph)
            0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_write = mr; o.ir_write = mr; end
            1: begin o.alu_src_b = 2'b11; o.illegal = (cls(op, fn) == 6); end
            2: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
            3: begin o.mem_read = 1; o.iord = 1; end
            4: begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
            5: begin o.mem_write = 1; o.iord = 1; o.instr_done = mr; end
            6: begin
                o.alu_src_a = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
                o.alu_op = a[3:0];
            end
            7: begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; o.alu_op = a[3:0]; end
            8: begin
                o.alu_src_a = 2'b01; o.alu_op = 4'b0001; o.pc_source = 2'b01;
                o.pc_write = z; o.instr_done = 1;
            end
            9: begin o.pc_source = 2'b10; o.pc_write = 1; o.instr_done = 1; end
            10: begin
                o.alu_src_a = 2'b01; o.alu_src_b = 2'b10;
                o.alu_op = ori ? 4'b0011 : 4'b0000; o.ext_op = !ori;
            end
            11: begin
                o.reg_write = 1; o.instr_done = 1;
                o.alu_op = ori ? 4'b0011 : 4'b0000; o.ext_op = !ori;
            end
            15: o.halted = 1;
            default: ;
        endcase
        return o;
    endfunction

    // Single compare process against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (dut_o !== exp_o) begin
                n_err++;
                $display("FAIL model t=%0t state=%0d got=%07h want=%07h",
                         $time, dut_o.state, dut_o, exp_o);
            end
            seen.push_back(int'(dut_o.state));
            snap[dut_o.state] = dut_o;
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic lit_seq(input string name, input string want);
        string s;
        s = "";
        foreach (seen[i]) s = {s, $sformatf("%0d,", seen[i])};
        n_vec++;
        if (s != want) begin
            n_err++;
            $display("FAIL %s got=%s want=%s", name, s, want);
        end
    endtask

    task automatic clear_obs();
        seen.delete();
        foreach (snap[i]) snap[i] = '0;
    endtask

    task automatic drive(input int ph, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr);
        opcode = op;
        funct = fn;
        zero = z;
        mem_ready = mr;
        exp_o = model(ph, op, fn, z, mr, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_o = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // wf / wm: mem_ready-low cycles in FETCH / in the data access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm);
        make_plan(cls(op, fn));
        foreach (plan[i]) begin
            int ph;
            ph = plan[i];
            if (ph == 0 || ph == 3 || ph == 5) begin
                int w;
                w = (ph == 0) ? wf : wm;
                for (int k = 0; k <= w; k++) begin
                    if (k == int'(TO)) begin
                        for (int h = 0; h < 3; h++)
                            drive(15, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
                        do_reset();
                        return;
                    end
                    drive(ph, (ph == 0) ? 6'($urandom) : op, (ph == 0) ? 6'($urandom) : fn,
                          1'($urandom), 1'(k == w));
                end
            end else begin
                drive(ph, op, fn, (ph == 8) ? z : 1'($urandom), 1'($urandom));
            end
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60) return 0;
        if (r < 90) return $urandom_range(1, 3);
        if (r < 97) return int'(TO) - 1;
        return int'(TO);
    endfunction

    localparam logic [5:0] R_FUNCTS [10] =
        '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h2a, 6'h2b};

    initial begin
        string s;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_outputs", 32'(dut_o), 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset in the middle of EXEC_R.
        drive(0, 6'h3f, 6'h3f, 1'b0, 1'b1);
        drive(1, OP_R, 6'h20, 1'b0, 1'b0);
        opcode = OP_R; funct = 6'h20;
        exp_o = model(6, OP_R, 6'h20, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        exp_o = '0;
        #1;
        lit("rst_mid_exec_r", 32'(dut_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        exp_o = model(0, OP_R, 6'h20, 1'b0, 1'b1, 1'b0);
        #1;
        lit("post_rst_mem_read", 32'(mem_read), 32'h1);
        lit("post_rst_alu_src_b", 32'(alu_src_b), 32'h1);
        @(posedge clk); #1;
        drive(1, OP_R, 6'h20, 1'b0, 1'b0);
        drive(6, OP_R, 6'h20, 1'b0, 1'b0);
        drive(7, OP_R, 6'h20, 1'b0, 1'b0);

        // ADD, zero-wait.
        clear_obs();
        run_instr(OP_R, 6'h20, 1'b0, 0, 0);
        lit_seq("add_seq", "0,1,6,7,");
        lit("add_rwb", {snap[7].reg_write, snap[7].reg_dst, snap[7].alu_op,
                        snap[7].instr_done}, 32'b1_1_0000_1);

        // LW with two stall cycles in MEM_RD.
        clear_obs();
        run_instr(OP_LW, 6'h00, 1'b0, 0, 2);
        lit_seq("lw_seq", "0,1,2,3,3,3,4,");
        lit("lw_mem_to_reg", 32'(snap[4].mem_to_reg), 32'h1);

        // BEQ taken / not taken.
        clear_obs();
        run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
        lit_seq("beq1_seq", "0,1,8,");
        lit("beq1_pc", {snap[8].pc_write, snap[8].pc_source}, 32'b1_01);
        clear_obs();
        run_instr(OP_BEQ, 6'h00, 1'b0, 0, 0);
        lit_seq("beq0_seq", "0,1,8,");
        lit("beq0_pc", {snap[8].pc_write, snap[8].pc_source}, 32'b0_01);

        // SRA and ORI.
        clear_obs();
        run_instr(OP_R, 6'h03, 1'b0, 0, 0);
        lit("sra_exec", {snap[6].alu_src_a, snap[6].alu_op}, 32'b10_0111);
        clear_obs();
        run_instr(OP_ORI, 6'h15, 1'b0, 0, 0);
        lit("ori_exec", {snap[10].ext_op, snap[10].alu_op}, 32'b0_0011);
        lit("ori_iwb", {snap[11].ext_op, snap[11].alu_op, snap[11].reg_write}, 32'b0_0011_1);

        // Illegal opcode, then back in FETCH.
        clear_obs();
        run_instr(6'h3f, 6'h20, 1'b0, 0, 0);
        drive(0, 6'h00, 6'h00, 1'b0, 1'b0);
        lit_seq("illegal_seq", "0,1,0,");
        lit("illegal_pulse", {snap[1].illegal, snap[1].pc_write, snap[1].ir_write,
                              snap[1].reg_write, snap[1].mem_write}, 32'b1_0000);
        drive(0, 6'h00, 6'h00, 1'b0, 1'b1);
        drive(1, OP_J, 6'h00, 1'b0, 1'b0);
        drive(9, OP_J, 6'h00, 1'b0, 1'b0);

        // Watchdog: 16 stalled fetch cycles halt; ready on the 16th completes.
        clear_obs();
        run_instr(OP_J, 6'h00, 1'b0, int'(TO), 0);
        s = "";
        for (int i = 0; i < int'(TO); i++) s = {s, "0,"};
        lit_seq("timeout_seq", {s, "15,15,15,0,0,"});
        lit("timeout_halted", 32'(snap[15].halted), 32'h1);
        clear_obs();
        run_instr(OP_J, 6'h00, 1'b0, int'(TO) - 1, 0);
        lit_seq("ready_on_last_seq", {s, "1,9,"});

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            int         c;
            logic [5:0] op, fn;
            c = $urandom_range(0, 6);
            fn = 6'($urandom);
            case (c)
                0: begin op = OP_R; fn = R_FUNCTS[$urandom_range(0, 9)]; end
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = ($urandom_range(0, 1) != 0) ? OP_ORI : OP_ADDI;
                default: begin
                    if ($urandom_range(0, 1) != 0) begin
                        op = OP_R;
                        while (alu_of(fn)[4]) fn = 6'($urandom);
                    end else begin
                        op = 6'($urandom);
                        while (cls(op, fn) != 6) op = 6'($urandom);
                    end
                end
            endcase
            run_instr(op, fn, 1'($urandom), pick_wait(), pick_wait());
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
